// File: rtl/jpeg_seq_ctrl_if.sv
// Handshake and buffer-address bundle between the JPEG sequencing controller
// and the pixel buffer / DCT / quantiser / entropy-coder datapath.
// master: the sequencing controller. slave: the datapath side.
interface jpeg_seq_ctrl_if;
    logic        start;
    logic        pix_valid;
    logic        dct_valid;
    logic        ent_busy;
    logic [18:0] bufaddr_in;
    logic [18:0] bufaddr_out;
    logic [1:0]  data_select;
    logic        enable_dct;
    logic        enable_QT;
    logic [3:0]  blk_cnt;
    logic        ctrl_busy;
    logic        frame_done;
    logic        err;

    modport master (
        input  start, pix_valid, dct_valid, ent_busy,
        output bufaddr_in, bufaddr_out, data_select, enable_dct, enable_QT,
               blk_cnt, ctrl_busy, frame_done, err
    );

    modport slave (
        output start, pix_valid, dct_valid, ent_busy,
        input  bufaddr_in, bufaddr_out, data_select, enable_dct, enable_QT,
               blk_cnt, ctrl_busy, frame_done, err
    );
endinterface

// File: rtl/jpeg_seq_ctrl.sv
// JPEG frame sequencer: loads one frame of pixels into the buffer, then walks
// 16 blocks per component (Y, Cb, Cr) through DCT feed, DCT drain and the
// entropy-coder wait, and pulses frame_done at the end.
// Optional feature: define JPEG_SEQ_WDOG_EN to add a watchdog over DRAIN and
// WAIT_ENT that sets the sticky err flag and ends the frame after WDOG_MAX
// idle cycles. Without it err is tied low and those states wait forever.
module jpeg_seq_ctrl #(
    parameter int PIX_TOTAL = 1024,
    parameter int WDOG_MAX  = 4095
) (
    input  logic           clock,
    input  logic           nrst,
    jpeg_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, WAIT_ENT, DONE} state_t;

    state_t      state, state_nxt;
    logic [18:0] wr_addr;
    logic [3:0]  blk;
    logic [1:0]  comp;
    logic [2:0]  row;
    logic [3:0]  dv_cnt;    // DCT rows seen for the current block, saturates at 8

    logic last_pix, dv_done, ent_free, last_blk, wd_trip;

    assign last_pix = bus.pix_valid && (wr_addr == 19'(PIX_TOTAL - 1));
    // Eighth row either already counted (all arrived during FEED) or arriving now
    assign dv_done  = (dv_cnt == 4'd8) || (bus.dct_valid && dv_cnt == 4'd7);
    assign ent_free = !bus.ent_busy;
    assign last_blk = (blk == 4'hF) && (comp == 2'd2);

`ifdef JPEG_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_MAX + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    // Trips on the cycle the idle count would reach WDOG_MAX, unless the
    // state is leaving normally in the same cycle
    assign wd_trip = !bus.dct_valid && (wd_cnt == WD_W'(WDOG_MAX - 1)) &&
                     ((state == DRAIN && !dv_done) || (state == WAIT_ENT && !ent_free));

    // Watchdog counter: runs in DRAIN/WAIT_ENT, cleared by dct_valid and by any state change
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state == DRAIN || state == WAIT_ENT) && state_nxt == state && !bus.dct_valid)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_trip)
                err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign wd_trip = 1'b0;
    assign bus.err = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.start) state_nxt = LOAD;
            LOAD:     if (last_pix) state_nxt = FEED;
            FEED:     if (row == 3'd7) state_nxt = DRAIN;
            DRAIN:    if (dv_done) state_nxt = WAIT_ENT;
                      else if (wd_trip) state_nxt = DONE;
            WAIT_ENT: if (ent_free) state_nxt = last_blk ? DONE : FEED;
                      else if (wd_trip) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Frame datapath: write address, block/component position, feed row, DCT row count
    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            wr_addr <= '0;
            blk     <= '0;
            comp    <= '0;
            row     <= '0;
            dv_cnt  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    wr_addr <= '0;
                    blk     <= '0;
                    comp    <= '0;
                end
                LOAD: begin
                    if (bus.pix_valid) wr_addr <= wr_addr + 19'd1;
                    if (last_pix) begin
                        row    <= '0;
                        dv_cnt <= '0;
                    end
                end
                FEED: begin
                    row <= row + 3'd1;
                    if (bus.dct_valid && dv_cnt != 4'd8) dv_cnt <= dv_cnt + 4'd1;
                end
                DRAIN: if (bus.dct_valid && dv_cnt != 4'd8) dv_cnt <= dv_cnt + 4'd1;
                WAIT_ENT: if (ent_free && !last_blk) begin
                    blk    <= blk + 4'd1;
                    if (blk == 4'hF) comp <= comp + 2'd1;
                    row    <= '0;
                    dv_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; row address is {blk_row, feed_row, blk_col}
    always_comb begin
        bus.ctrl_busy   = (state != IDLE);
        bus.enable_dct  = (state == FEED) || (state == DRAIN);
        bus.enable_QT   = ((state == FEED) || (state == DRAIN)) && bus.dct_valid;
        bus.frame_done  = (state == DONE);
        bus.bufaddr_out = (state == FEED) ? 19'({blk[3:2], row, blk[1:0]}) : 19'd0;
        bus.bufaddr_in  = wr_addr;
        bus.data_select = comp;
        bus.blk_cnt     = blk;
    end
endmodule
